// File: rtl/noc_out_port_arbiter_pkg.sv
// Shared types and flit-type codes for the output-port arbiter slice.
// Ports: none (package only).
// Flit codes match the router's existing one-hot HEADER/BODY/TAIL encoding.
package noc_out_port_arbiter_pkg;

  typedef logic [2:0] flit_type_t;

  localparam flit_type_t FLIT_HEADER = 3'b001;
  localparam flit_type_t FLIT_BODY   = 3'b010;
  localparam flit_type_t FLIT_TAIL   = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_out_port_arbiter_rr_pick.sv
// Rotate-priority selector: first set request bit searching from last_i+1 (mod N_REQ).
// Latency: purely combinational. Backpressure: none, the caller decides when to consume.
// Ports: req_i request vector, last_i previous winner, found_o any request, index_o winner.
module noc_out_port_arbiter_rr_pick
  import noc_out_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic             found_o,
  output logic [IW-1:0]    index_o
);

  int          cand;
  logic [IW-1:0] cidx;

  // Walk offsets from farthest to nearest so the nearest candidate after
  // last_i is the final assignment and therefore wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = 0;
    cidx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last_i) + k) % N_REQ;
      cidx = cand[IW-1:0];
      if (req_i[cidx]) begin
        found_o = 1'b1;
        index_o = cidx;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Per-output-port packet arbiter: round-robin on HEADER, holds grant until TAIL, credit-gated.
// Latency: HEADER in IDLE at t -> first grant at t+1; one bubble cycle between packets.
// Backpressure: grant drops while the owner's FIFO is empty or no downstream credit is left.
// Ports: req/flit_type_in per input, credit_in pulse from downstream; grant (FIFO read
// enables), sel (crossbar select), valid_out (downstream write), credits, credit_err (sticky).
module noc_out_port_arbiter
  import noc_out_port_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CREDIT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [3*N_REQ-1:0]       flit_type_in,
  input  logic                     credit_in,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     valid_out,
  output logic [CREDIT_W-1:0]      credits,
  output logic                     credit_err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(BUF_DEPTH);

  arb_state_t          state_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       last_q;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                credit_err_q, credit_err_d;

  logic [N_REQ-1:0]    hdr_req;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic                owner_req;
  flit_type_t          owner_type;
  logic                xfer;

  // Only inputs presenting a HEADER may compete for an idle port.
  always_comb begin
    hdr_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hdr_req[i] = req[i] && (flit_type_in[3*i +: 3] == FLIT_HEADER);
    end
  end

  noc_out_port_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i   (hdr_req),
    .last_i  (last_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_type = FLIT_BODY;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req  = req[i];
        owner_type = flit_type_in[3*i +: 3];
      end
    end
  end

  // Grant is combinational so the owner's flit moves in the same cycle.
  always_comb begin
    grant = '0;
    if ((state_q == ST_LOCKED) && owner_req && (credits_q != '0)) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign xfer       = |grant;
  assign valid_out  = xfer;
  assign sel        = owner_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (xfer && (owner_type == FLIT_TAIL)) begin
            last_q  <= owner_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A transfer and a returned credit in the same cycle cancel out.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case ({xfer, credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + 1'b1;
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
module tb_noc_out_port_arbiter;
  import noc_out_port_arbiter_pkg::*;

  localparam flit_type_t H = FLIT_HEADER;
  localparam flit_type_t B = FLIT_BODY;
  localparam flit_type_t T = FLIT_TAIL;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] flit_type_in;
  logic        credit_in;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        valid_out;
  logic [2:0]  credits;
  logic        credit_err;

  int tests = 0;
  int fails = 0;

  noc_out_port_arbiter #(
    .N_REQ     (4),
    .BUF_DEPTH (4),
    .CREDIT_W  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .flit_type_in (flit_type_in),
    .credit_in    (credit_in),
    .grant        (grant),
    .sel          (sel),
    .valid_out    (valid_out),
    .credits      (credits),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] r, input flit_type_t f3, input flit_type_t f2,
                        input flit_type_t f1, input flit_type_t f0, input logic c);
    req          = r;
    flit_type_in = {f3, f2, f1, f0};
    credit_in    = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(4'b0000, B, B, B, B, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Round-robin table: types of inputs 0,1,3, credit_in, expected grant and sel.
  flit_type_t rr_t0 [11] = '{H, H, T, H, H, H, H, H, H, H, H};
  flit_type_t rr_t1 [11] = '{H, H, H, H, H, T, H, H, H, H, H};
  flit_type_t rr_t3 [11] = '{H, H, H, H, H, H, H, H, T, H, H};
  logic       rr_c  [11] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  logic [3:0] rr_g  [11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                             4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
  logic [1:0] rr_s  [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                             2'd1, 2'd3, 2'd3, 2'd3, 2'd0};

  initial begin
    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_err", 32'(credit_err), 32'h0);

    // Single packet on input 0, no contention
    set_in(4'b0001, B, B, B, H, 1'b0);
    chk("sp_idle_grant", 32'(grant), 32'h0);
    tick();
    set_in(4'b0001, B, B, B, H, 1'b0);
    chk("sp_hdr_grant", 32'(grant), 32'h1);
    chk("sp_hdr_valid", 32'(valid_out), 32'h1);
    tick();
    set_in(4'b0001, B, B, B, B, 1'b0);
    chk("sp_b1_grant", 32'(grant), 32'h1);
    chk("sp_b1_credits", 32'(credits), 32'd3);
    tick();
    set_in(4'b0001, B, B, B, B, 1'b0);
    chk("sp_b2_grant", 32'(grant), 32'h1);
    chk("sp_b2_credits", 32'(credits), 32'd2);
    tick();
    set_in(4'b0001, B, B, B, T, 1'b0);
    chk("sp_tail_grant", 32'(grant), 32'h1);
    chk("sp_tail_credits", 32'(credits), 32'd1);
    tick();
    set_in(4'b0000, B, B, B, B, 1'b0);
    chk("sp_after_grant", 32'(grant), 32'h0);
    chk("sp_after_credits", 32'(credits), 32'd0);
    chk("sp_after_valid", 32'(valid_out), 32'h0);

    // Round-robin over inputs 0,1,3 with balanced credits
    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_in(4'b1011, rr_t3[i], B, rr_t1[i], rr_t0[i], rr_c[i]);
      chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(rr_g[i]));
      chk($sformatf("rr_sel_%0d", i), 32'(sel), 32'(rr_s[i]));
      chk($sformatf("rr_credits_%0d", i), 32'(credits), 32'd4);
      tick();
    end

    // No interleave: input 2 owns the port, input 0 raises a HEADER mid-packet
    do_reset();
    set_in(4'b0100, B, H, B, B, 1'b0);
    chk("ni_idle", 32'(grant), 32'h0);
    tick();
    set_in(4'b0100, B, H, B, B, 1'b1);
    chk("ni_hdr", 32'(grant), 32'h4);
    tick();
    set_in(4'b0101, B, B, B, H, 1'b1);
    chk("ni_b1", 32'(grant), 32'h4);
    chk("ni_b1_sel", 32'(sel), 32'd2);
    tick();
    set_in(4'b0101, B, B, B, H, 1'b1);
    chk("ni_b2", 32'(grant), 32'h4);
    tick();
    set_in(4'b0101, B, T, B, H, 1'b1);
    chk("ni_tail", 32'(grant), 32'h4);
    tick();
    set_in(4'b0001, B, B, B, H, 1'b0);
    chk("ni_bubble", 32'(grant), 32'h0);
    chk("ni_bubble_credits", 32'(credits), 32'd4);
    tick();
    set_in(4'b0001, B, B, B, H, 1'b0);
    chk("ni_next_owner", 32'(grant), 32'h1);
    chk("ni_next_sel", 32'(sel), 32'd0);

    // Credit stall: 6-flit packet on input 1 with no credits returned
    do_reset();
    set_in(4'b0010, B, B, H, B, 1'b0);
    tick();
    set_in(4'b0010, B, B, H, B, 1'b0);
    chk("cs_hdr", 32'(grant), 32'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0010, B, B, B, B, 1'b0);
      chk($sformatf("cs_body_%0d", i), 32'(grant), 32'h2);
      tick();
    end
    set_in(4'b0010, B, B, B, B, 1'b0);
    chk("cs_stall_grant", 32'(grant), 32'h0);
    chk("cs_stall_credits", 32'(credits), 32'd0);
    tick();
    set_in(4'b0010, B, B, B, B, 1'b1);
    chk("cs_stall2_grant", 32'(grant), 32'h0);
    tick();
    set_in(4'b0010, B, B, B, B, 1'b0);
    chk("cs_resume_credits", 32'(credits), 32'd1);
    chk("cs_resume_grant", 32'(grant), 32'h2);
    tick();
    set_in(4'b0010, B, B, T, B, 1'b1);
    chk("cs_again_stall", 32'(grant), 32'h0);
    tick();

    // Transfer plus credit_in in the same cycle, then overflow
    set_in(4'b0010, B, B, T, B, 1'b1);
    chk("tc_grant", 32'(grant), 32'h2);
    chk("tc_credits_before", 32'(credits), 32'd1);
    tick();
    set_in(4'b0010, B, B, B, B, 1'b1);
    chk("tc_credits_after", 32'(credits), 32'd1);
    chk("tc_body_ignored", 32'(grant), 32'h0);
    tick();
    set_in(4'b0010, B, B, B, B, 1'b1);
    chk("ov_body_ignored", 32'(grant), 32'h0);
    chk("ov_credits2", 32'(credits), 32'd2);
    tick();
    set_in(4'b0000, B, B, B, B, 1'b1);
    chk("ov_credits3", 32'(credits), 32'd3);
    tick();
    set_in(4'b0000, B, B, B, B, 1'b1);
    chk("ov_credits4", 32'(credits), 32'd4);
    chk("ov_err_clear", 32'(credit_err), 32'h0);
    tick();
    set_in(4'b0000, B, B, B, B, 1'b0);
    chk("ov_err_set", 32'(credit_err), 32'h1);
    chk("ov_credits_sat", 32'(credits), 32'd4);
    tick();
    chk("ov_err_sticky", 32'(credit_err), 32'h1);

    // Reset mid-packet (credit_err still set from above)
    set_in(4'b0010, B, B, H, B, 1'b0);
    tick();
    set_in(4'b0010, B, B, H, B, 1'b0);
    chk("rm_hdr", 32'(grant), 32'h2);
    tick();
    rst = 1'b1;
    set_in(4'b0010, B, B, B, B, 1'b0);
    chk("rm_body", 32'(grant), 32'h2);
    tick();
    rst = 1'b0;
    set_in(4'b1111, H, H, H, H, 1'b0);
    chk("rm_grant", 32'(grant), 32'h0);
    chk("rm_credits", 32'(credits), 32'd4);
    chk("rm_err", 32'(credit_err), 32'h0);
    chk("rm_sel", 32'(sel), 32'd0);
    tick();
    set_in(4'b1111, H, H, H, H, 1'b0);
    chk("rm_first", 32'(grant), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
